led_mode_controller: RTL and testbench
======================================

# led_mode_controller

Sequencer for the board's two-button / two-LED front panel. Derives a slow tick from `CLK`, debounces both buttons, and runs a four-state mode FSM stepped by a two-button chord. Drives `LED1`/`LED2` with registered button-echo, alternating-blink, synchronous-blink or off patterns. Sits directly between the board pins and the LEDs and replaces ad-hoc per-design blink logic.

## Interface
- `CLK_DIV_BITS`, default 12: tick prescaler width; one tick every 2^`CLK_DIV_BITS` `CLK` cycles (100 MHz / 4096 ≈ 24.4 kHz).
- `HALF_PERIOD`, default 12207: ticks per blink half-period (≈0.5 s).
- `LOCKOUT_TICKS`, default 16383: ticks after reset or a mode step during which the chord is ignored.
- `CLK`, in, 1: single system clock; all state on rising edge.
- `RST_N`, in, 1: reset, asynchronous assert, active-low.
- `BUT1`, in, 1: button 1, active-low, asynchronous to `CLK`.
- `BUT2`, in, 1: button 2, active-low, asynchronous to `CLK`.
- `LED1`, out, 1: LED 1, active-high, registered.
- `LED2`, out, 1: LED 2, active-high, registered.
- `MODE`, out, 2: current FSM state, registered.

## Operation
- Prescaler: free-running `CLK_DIV_BITS`-bit up-counter, wraps. `tick` is a one-`CLK` pulse when the counter equals all-ones. All logic below advances only on `tick` cycles, except the synchronizers.
- Synchronizers: each button passes through 2 flops on `CLK`. Reset value 1 (released).
- Debounce: per button, a 3-bit shift register loaded from the synchronized value on each tick.
  - Debounced level goes to 0 when the shifter is 000 and to 1 when it is 111. Otherwise it holds.
  - Reset value 1.
- Lockout counter: width ceil(log2(`LOCKOUT_TICKS`+1)).
  - Loads `LOCKOUT_TICKS` on reset and on every mode step.
  - Otherwise decrements by 1 per tick and saturates at 0.
- Chord: on a tick with both debounced levels 0 and lockout == 0, the mode steps. A continuously held chord therefore steps once every `LOCKOUT_TICKS`+1 ticks.
- Mode FSM: `ECHO`(0) -> `ALT`(1) -> `SYNC`(2) -> `OFF`(3) -> `ECHO`, wrapping. Reset state is `ALT`.
- Phase counter:
  - Counts ticks from 0 to 2·`HALF_PERIOD`−1, then wraps to 0.
  - `phase` = 0 while count < `HALF_PERIOD`, else 1.
  - Clears to 0 on every mode step.
  - Runs in all modes.
- LED rule, applied on each tick using the mode and phase values after that tick's update:
  - `ECHO`: `LED1` = ~debounced1, `LED2` = ~debounced2.
  - `ALT`: phase 0 gives `LED1`=1, `LED2`=0; phase 1 gives `LED1`=0, `LED2`=1.
  - `SYNC`: `LED1` = `LED2` = ~phase.
  - `OFF`: both 0.
- Reset values: `LED1`=0, `LED2`=0, `MODE`=1, prescaler 0, phase counter 0, lockout = `LOCKOUT_TICKS`.

## Timing
- Tick period is exactly 2^`CLK_DIV_BITS` `CLK` cycles. The first tick occurs 2^`CLK_DIV_BITS` cycles after `RST_N` deasserts.
- Button to debounced level: 2 `CLK` cycles of synchronization, then 3 consecutive ticks of stable level. The level changes on the third such tick.
- Chord to `MODE`: `MODE` updates on the `CLK` edge of the qualifying tick. `LED1`/`LED2` reflect the new mode on that same edge, since the LED logic uses the post-update mode with phase = 0.
- Blink: in `ALT`/`SYNC` the LEDs toggle every `HALF_PERIOD` ticks. The first toggle comes `HALF_PERIOD` ticks after a mode step or reset.
- Mid-operation reset: `RST_N` low immediately forces all reset values, regardless of `CLK`. No tick is generated while reset is held.
- Single-button press in a non-`ECHO` mode: LED outputs are unchanged; only the debounced state updates.
- Chord while lockout > 0: ignored. It is not latched for later.

## Test plan
Bench parameters: `CLK_DIV_BITS`=2, `HALF_PERIOD`=5, `LOCKOUT_TICKS`=8.
- Reset check: hold `RST_N`=0 for 10 cycles, then release with buttons released → `MODE`=1, `LED1`=1/`LED2`=0 after the first tick; LEDs swap every 20 `CLK` cycles.
- Chord during lockout: assert the chord from tick 2 to tick 12 → no step before tick 9. `MODE` goes 1→2 at the first tick where debounced levels are both 0 and lockout == 0. After that, `LED1`=`LED2`=1 for 5 ticks, then both 0.
- Mode wrap: hold the chord continuously for 40 ticks after lockout → `MODE` steps every 9 ticks: 2→3→0→1→2.
- Debounce in `ECHO`: set `BUT1`=0 for 2 ticks, then 1 → `LED1` stays 0. Set `BUT1`=0 for 3 ticks → `LED1`=1 on the third tick.
- Mid-operation reset: assert `RST_N` mid-blink in `SYNC` at an arbitrary `CLK` phase → outputs go to reset values asynchronously; `MODE`=1 after release.

Source files
------------

// File: rtl/led_mode_controller.sv
// Front-panel sequencer: slow tick prescaler, two debounced buttons, and a
// four-mode LED pattern FSM stepped by pressing both buttons together.
module led_mode_controller #(
    parameter int CLK_DIV_BITS  = 12,
    parameter int HALF_PERIOD   = 12207,
    parameter int LOCKOUT_TICKS = 16383
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BUT1,
    input  logic       BUT2,
    output logic       LED1,
    output logic       LED2,
    output logic [1:0] MODE
);

    localparam int LOCK_W = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;
    localparam int PH_W   = (HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;

    typedef enum logic [1:0] {
        ECHO = 2'd0,
        ALT  = 2'd1,
        SYNC = 2'd2,
        OFF  = 2'd3
    } mode_e;

    logic [CLK_DIV_BITS-1:0] prescCnt_q;
    logic [1:0]              sync1_q, sync2_q;
    logic [2:0]              shift1_q, shift1_d, shift2_q, shift2_d;
    logic                    deb1_q, deb1_d, deb2_q, deb2_d;
    logic [LOCK_W-1:0]       lockCnt_q, lockCnt_d;
    logic [PH_W-1:0]         phaseCnt_q, phaseCnt_d;
    mode_e                   mode_q, mode_d;
    logic                    led1_q, led1_d, led2_q, led2_d;
    logic                    tick, step, phase;

    assign tick = &prescCnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prescCnt_q <= '0;
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            shift1_q   <= 3'b111;
            shift2_q   <= 3'b111;
            deb1_q     <= 1'b1;
            deb2_q     <= 1'b1;
            lockCnt_q  <= LOCK_W'(LOCKOUT_TICKS);
            phaseCnt_q <= '0;
            mode_q     <= ALT;
            led1_q     <= 1'b0;
            led2_q     <= 1'b0;
        end else begin
            prescCnt_q <= prescCnt_q + CLK_DIV_BITS'(1);
            sync1_q    <= {sync1_q[0], BUT1};
            sync2_q    <= {sync2_q[0], BUT2};
            shift1_q   <= shift1_d;
            shift2_q   <= shift2_d;
            deb1_q     <= deb1_d;
            deb2_q     <= deb2_d;
            lockCnt_q  <= lockCnt_d;
            phaseCnt_q <= phaseCnt_d;
            mode_q     <= mode_d;
            led1_q     <= led1_d;
            led2_q     <= led2_d;
        end
    end

    // The chord is judged on the debounced levels held before this tick;
    // the LEDs use the mode, phase and debounced levels after it.
    always_comb begin
        shift1_d   = shift1_q;
        shift2_d   = shift2_q;
        deb1_d     = deb1_q;
        deb2_d     = deb2_q;
        lockCnt_d  = lockCnt_q;
        phaseCnt_d = phaseCnt_q;
        mode_d     = mode_q;
        led1_d     = led1_q;
        led2_d     = led2_q;
        step       = 1'b0;
        phase      = 1'b0;

        if (tick) begin
            shift1_d = {shift1_q[1:0], sync1_q[1]};
            shift2_d = {shift2_q[1:0], sync2_q[1]};
            if (shift1_d == 3'b000)      deb1_d = 1'b0;
            else if (shift1_d == 3'b111) deb1_d = 1'b1;
            if (shift2_d == 3'b000)      deb2_d = 1'b0;
            else if (shift2_d == 3'b111) deb2_d = 1'b1;

            step = !deb1_q && !deb2_q && (lockCnt_q == '0);

            if (step) begin
                lockCnt_d  = LOCK_W'(LOCKOUT_TICKS);
                phaseCnt_d = '0;
                case (mode_q)
                    ECHO:    mode_d = ALT;
                    ALT:     mode_d = SYNC;
                    SYNC:    mode_d = OFF;
                    default: mode_d = ECHO;
                endcase
            end else begin
                if (lockCnt_q != '0) lockCnt_d = lockCnt_q - LOCK_W'(1);
                if (phaseCnt_q == PH_W'(2 * HALF_PERIOD - 1)) phaseCnt_d = '0;
                else phaseCnt_d = phaseCnt_q + PH_W'(1);
            end

            phase = (phaseCnt_d >= PH_W'(HALF_PERIOD));

            case (mode_d)
                ECHO: begin
                    led1_d = ~deb1_d;
                    led2_d = ~deb2_d;
                end
                ALT: begin
                    led1_d = ~phase;
                    led2_d = phase;
                end
                SYNC: begin
                    led1_d = ~phase;
                    led2_d = ~phase;
                end
                default: begin
                    led1_d = 1'b0;
                    led2_d = 1'b0;
                end
            endcase
        end
    end

    assign LED1 = led1_q;
    assign LED2 = led2_q;
    assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Bench for led_mode_controller: directed and randomized button sequences
// checked tick by tick against a behavioural model of the panel rules.
module tb_led_mode_controller;

    localparam int CLK_DIV_BITS  = 2;
    localparam int HALF_PERIOD   = 5;
    localparam int LOCKOUT_TICKS = 8;

    logic       CLK;
    logic       RST_N;
    logic       BUT1;
    logic       BUT2;
    logic       LED1;
    logic       LED2;
    logic [1:0] MODE;

    int testCount = 0;
    int failCount = 0;

    // Model state: ticks since reset or last step, last three samples per button.
    int   modeM;
    int   sinceM;
    int   deb1M, deb2M;
    int   hist1[$], hist2[$];
    logic expLed1, expLed2;
    logic [1:0] expMode;

    led_mode_controller #(
        .CLK_DIV_BITS (CLK_DIV_BITS),
        .HALF_PERIOD  (HALF_PERIOD),
        .LOCKOUT_TICKS(LOCKOUT_TICKS)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BUT1 (BUT1),
        .BUT2 (BUT2),
        .LED1 (LED1),
        .LED2 (LED2),
        .MODE (MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit allEqual(input int q[$], input int v);
        foreach (q[i]) if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        modeM   = 1;
        sinceM  = 0;
        deb1M   = 1;
        deb2M   = 1;
        hist1   = '{1, 1, 1};
        hist2   = '{1, 1, 1};
        expLed1 = 1'b0;
        expLed2 = 1'b0;
        expMode = 2'd1;
    endtask

    task automatic modelTick(input logic b1, input logic b2);
        bit doStep;
        bit phaseM;
        doStep = (deb1M == 0) && (deb2M == 0) && (sinceM >= LOCKOUT_TICKS);
        hist1.push_back(int'(b1));
        hist2.push_back(int'(b2));
        if (hist1.size() > 3) void'(hist1.pop_front());
        if (hist2.size() > 3) void'(hist2.pop_front());
        if (allEqual(hist1, 0)) deb1M = 0;
        if (allEqual(hist1, 1)) deb1M = 1;
        if (allEqual(hist2, 0)) deb2M = 0;
        if (allEqual(hist2, 1)) deb2M = 1;
        if (doStep) begin
            modeM  = (modeM + 1) % 4;
            sinceM = 0;
        end else begin
            sinceM++;
        end
        phaseM = ((sinceM % (2 * HALF_PERIOD)) >= HALF_PERIOD);
        case (modeM)
            0: begin expLed1 = (deb1M == 0); expLed2 = (deb2M == 0); end
            1: begin expLed1 = !phaseM;      expLed2 = phaseM;       end
            2: begin expLed1 = !phaseM;      expLed2 = !phaseM;      end
            default: begin expLed1 = 1'b0;   expLed2 = 1'b0;         end
        endcase
        expMode = 2'(modeM);
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] em,
                               input logic e1, input logic e2);
        testCount++;
        assert (MODE === em) else begin
            failCount++;
            $error("[TB] FAIL %s MODE: observed %0d expected %0d", tag, MODE, em);
        end
        testCount++;
        assert (LED1 === e1) else begin
            failCount++;
            $error("[TB] FAIL %s LED1: observed %0b expected %0b", tag, LED1, e1);
        end
        testCount++;
        assert (LED2 === e2) else begin
            failCount++;
            $error("[TB] FAIL %s LED2: observed %0b expected %0b", tag, LED2, e2);
        end
    endtask

    // Drive buttons, confirm nothing moves before the tick, then check the tick.
    task automatic applyStimulus(input logic b1, input logic b2, input string tag);
        BUT1 = b1;
        BUT2 = b2;
        repeat (3) @(posedge CLK);
        #1 checkOutput({tag, "_preTick"}, expMode, expLed1, expLed2);
        @(posedge CLK);
        modelTick(b1, b2);
        #1 checkOutput(tag, expMode, expLed1, expLed2);
    endtask

    initial begin
        logic r1, r2;
        RST_N = 1'b0;
        BUT1  = 1'b1;
        BUT2  = 1'b1;
        modelReset();
        repeat (10) @(negedge CLK);
        checkOutput("resetState", 2'd1, 1'b0, 1'b0);
        RST_N = 1'b1;

        applyStimulus(1'b1, 1'b1, "firstTick");
        for (int i = 2; i <= 12; i++) applyStimulus(1'b0, 1'b0, "chordLockout");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, "syncBlink");

        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, "modeWrap");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, "wrapRelease");

        for (int i = 0; i < 60 && modeM != 0; i++) applyStimulus(1'b0, 1'b0, "toEcho");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, "echoIdle");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, "echoShortPress");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, "echoShortRel");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "echoLongPress");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "echoBut2");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, "echoRelease");

        r1 = 1'b1;
        r2 = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) r1 = ~r1;
            if ($urandom_range(0, 3) == 0) r2 = ~r2;
            applyStimulus(r1, r2, "random");
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, "randRelease");

        for (int i = 0; i < 60 && modeM != 2; i++) applyStimulus(1'b0, 1'b0, "toSync");
        for (int i = 0; i < 3 + $urandom_range(0, 6); i++)
            applyStimulus(1'b1, 1'b1, "syncRun");
        #($urandom_range(1, 9));
        RST_N = 1'b0;
        #1 checkOutput("midReset", 2'd1, 1'b0, 1'b0);
        modelReset();
        repeat (3) @(negedge CLK);
        checkOutput("midResetHeld", 2'd1, 1'b0, 1'b0);
        RST_N = 1'b1;
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, "afterReset");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
